// File: rtl/gmem_srl_fifo_ctrl_pkg.sv
// Shared configuration helpers for the gmem SRL-backed FWFT FIFO.
package gmem_srl_fifo_ctrl_pkg;

  // A legal configuration needs room for at least one SRL entry plus the
  // output register, and enough read-address bits to reach every SRL entry.
  function automatic bit fifo_cfg_legal(input int depth, input int addr_width);
    longint cap;
    cap = longint'(64'sd1) <<< addr_width;
    return (depth >= 32'sd2) && (cap >= longint'(depth - 32'sd1));
  endfunction

  // Width needed to count every entry (SRL entries plus the output register).
  // For a legal configuration this is ADDR_WIDTH+1 at the smallest legal ADDR_WIDTH.
  function automatic int count_width(input int depth);
    return $clog2(depth - 32'sd1) + 32'sd1;
  endfunction

endpackage

// File: rtl/gmem_srl_fifo_ctrl_srl.sv
// gmem SRL storage: a shift register written at index 0 (older entries move
// up by one on every write) with a registered, address-selected output.
module kernel3_gmem_B_m_axi_srl
  import gmem_srl_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int N_ENT = DEPTH - 1;

  logic [DATA_WIDTH-1:0] mem_q [N_ENT];
  logic [DATA_WIDTH-1:0] mem_d [N_ENT];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic [DATA_WIDTH-1:0] rdata;

  // Shift a new word in at index 0; every held word ages by one slot.
  always_comb begin
    for (int i = 0; i < N_ENT; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[0] = din;
      for (int i = 1; i < N_ENT; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Read mux over the pre-edge contents; addresses past the last entry read zero.
  always_comb begin
    rdata = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < N_ENT; i++) begin
      if (raddr == ADDR_WIDTH'(i)) begin
        rdata = mem_q[i];
      end else begin
        rdata = rdata;
      end
    end
  end

  // Output register loads only on a read strobe.
  always_comb begin
    if (re) begin
      dout_d = rdata;
    end else begin
      dout_d = dout_q;
    end
  end

  // Storage array: no reset, contents are qualified by the controller's count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_ENT; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Output register: cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= {DATA_WIDTH{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/gmem_srl_fifo_ctrl.sv
// First-word-fall-through FIFO control around the gmem SRL storage.
// mcnt counts words held in the SRL; dout_vld marks the output register.
module gmem_srl_fifo_ctrl
  import gmem_srl_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   num_data_valid
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  if (!fifo_cfg_legal(DEPTH, ADDR_WIDTH) || (count_width(DEPTH) > CNT_W)) begin : g_cfg_bad
    $error("gmem_srl_fifo_ctrl: illegal DEPTH/ADDR_WIDTH combination");
  end

  logic [CNT_W-1:0]      mcnt_q;
  logic [CNT_W-1:0]      mcnt_d;
  logic                  dout_vld_q;
  logic                  dout_vld_d;
  logic                  push;
  logic                  pop;
  logic                  load;
  logic                  mcnt_nz;
  logic [CNT_W-1:0]      mcnt_m1;
  logic [ADDR_WIDTH-1:0] raddr;

  // Handshake qualifiers; all gated by clk_en so nothing moves while it is low.
  always_comb begin
    mcnt_nz   = (mcnt_q != {CNT_W{1'b0}});
    if_full_n = (mcnt_q != CNT_W'(DEPTH - 1));
    push      = clk_en & if_write & if_full_n;
    pop       = clk_en & if_read & dout_vld_q;
    load      = clk_en & mcnt_nz & (~dout_vld_q | pop);
  end

  // Oldest SRL word lives at mcnt-1; addressed from pre-edge state so it is
  // read before a same-edge shift moves it.
  always_comb begin
    mcnt_m1 = mcnt_q - CNT_W'(1);
    if (mcnt_nz) begin
      raddr = mcnt_m1[ADDR_WIDTH-1:0];
    end else begin
      raddr = {ADDR_WIDTH{1'b0}};
    end
  end

  // Occupancy and output-valid next state.
  always_comb begin
    mcnt_d     = mcnt_q;
    dout_vld_d = dout_vld_q;
    if (push && !load) begin
      mcnt_d = mcnt_q + CNT_W'(1);
    end else if (!push && load) begin
      mcnt_d = mcnt_q - CNT_W'(1);
    end else begin
      mcnt_d = mcnt_q;
    end
    if (load) begin
      dout_vld_d = 1'b1;
    end else if (pop) begin
      dout_vld_d = 1'b0;
    end else begin
      dout_vld_d = dout_vld_q;
    end
  end

  // Control state registers; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcnt_q     <= {CNT_W{1'b0}};
      dout_vld_q <= 1'b0;
    end else begin
      mcnt_q     <= mcnt_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  kernel3_gmem_B_m_axi_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .din   (if_din),
    .re    (load),
    .raddr (raddr),
    .dout  (if_dout)
  );

  assign if_empty_n     = dout_vld_q;
  assign num_data_valid = mcnt_q + CNT_W'(dout_vld_q);

endmodule

// File: tb/tb_gmem_srl_fifo_ctrl.sv
// Directed bench for gmem_srl_fifo_ctrl with DEPTH=4 (3 SRL entries + output reg).
module tb_gmem_srl_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   num_data_valid;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  gmem_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_en         (clk_en),
    .if_write       (if_write),
    .if_din         (if_din),
    .if_full_n      (if_full_n),
    .if_read        (if_read),
    .if_dout        (if_dout),
    .if_empty_n     (if_empty_n),
    .num_data_valid (num_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    if_write = 1'b1;
    if_din   = w;
    tick();
    if_write = 1'b0;
  endtask

  // Pop until empty, checking each popped word against exp_q; bounded.
  task automatic drain(input string tag, input int max_cycles);
    logic [31:0] e;
    if_read = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (if_empty_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq(tag, if_dout, e);
        end else begin
          check_eq({tag, "_extra"}, if_dout, 32'hDEAD_BEEF);
        end
      end
      if (!if_empty_n && num_data_valid == 3'd0) break;
      tick();
    end
    if_read = 1'b0;
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_nd0"}, 32'(num_data_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int          nxt;
    logic [31:0] e;
    reset    = 1'b1;
    clk_en   = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_full_n", 32'(if_full_n), 32'd1);
    check_eq("rst_empty_n", 32'(if_empty_n), 32'd0);
    check_eq("rst_nd", 32'(num_data_valid), 32'd0);
    check_eq("rst_dout", if_dout, 32'd0);

    // 1: single push, two-edge latency
    push_word(32'hA1);
    check_eq("t1_lat_empty_n", 32'(if_empty_n), 32'd0);
    check_eq("t1_lat_nd", 32'(num_data_valid), 32'd1);
    tick();
    check_eq("t1_empty_n", 32'(if_empty_n), 32'd1);
    check_eq("t1_dout", if_dout, 32'hA1);
    check_eq("t1_nd", 32'(num_data_valid), 32'd1);
    // push+pop with empty SRL: output empties, new word one cycle later
    if_read = 1'b1; if_write = 1'b1; if_din = 32'hB2;
    tick();
    if_read = 1'b0; if_write = 1'b0;
    check_eq("t1_pp_empty_n", 32'(if_empty_n), 32'd0);
    check_eq("t1_pp_nd", 32'(num_data_valid), 32'd1);
    tick();
    check_eq("t1_pp_dout", if_dout, 32'hB2);
    exp_q.push_back(32'hB2);
    drain("t1_drain", 8);

    // 2: fill to full, extra push dropped
    for (int i = 1; i <= 4; i++) begin
      push_word(32'(i));
      check_eq("t2_nd", 32'(num_data_valid), 32'(i));
      check_eq("t2_full_n", 32'(if_full_n), (i == 4) ? 32'd0 : 32'd1);
    end
    push_word(32'h5);
    check_eq("t2_drop_nd", 32'(num_data_valid), 32'd4);
    check_eq("t2_drop_full_n", 32'(if_full_n), 32'd0);

    // 3: full, continuous read+write for 16 cycles
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 15; i++) exp_q.push_back(32'h10 + 32'(i));
    nxt = 0;
    if_read = 1'b1; if_write = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if_din = 32'h10 + 32'(nxt);
      if (if_empty_n) begin
        e = exp_q.pop_front();
        check_eq("t3_order", if_dout, e);
      end else begin
        check_eq("t3_empty_n", 32'(if_empty_n), 32'd1);
      end
      if (if_full_n) nxt++;
      tick();
      check_eq("t3_nd", 32'(num_data_valid), 32'd3);
    end
    if_write = 1'b0;
    check_eq("t3_accepted", 32'(nxt), 32'd15);
    drain("t3_drain", 10);

    // 4: reads on empty FIFO have no effect
    if_read = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("t4_empty_n", 32'(if_empty_n), 32'd0);
      check_eq("t4_nd", 32'(num_data_valid), 32'd0);
      check_eq("t4_dout", if_dout, 32'h1E);
    end
    if_read = 1'b0;

    // 5: clk_en low freezes everything
    push_word(32'h31);
    push_word(32'h32);
    push_word(32'h33);
    tick();
    clk_en = 1'b0; if_read = 1'b1; if_write = 1'b1; if_din = 32'h99;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t5_dout", if_dout, 32'h31);
      check_eq("t5_nd", 32'(num_data_valid), 32'd3);
      check_eq("t5_empty_n", 32'(if_empty_n), 32'd1);
    end
    clk_en = 1'b1; if_write = 1'b0; if_read = 1'b0;
    exp_q.push_back(32'h31); exp_q.push_back(32'h32); exp_q.push_back(32'h33);
    drain("t5_drain", 8);

    // 6: reset mid-burst discards contents
    push_word(32'h41);
    push_word(32'h42);
    if_write = 1'b1; if_din = 32'h43; reset = 1'b1;
    tick();
    reset = 1'b0; if_write = 1'b0;
    check_eq("t6_empty_n", 32'(if_empty_n), 32'd0);
    check_eq("t6_full_n", 32'(if_full_n), 32'd1);
    check_eq("t6_nd", 32'(num_data_valid), 32'd0);
    check_eq("t6_dout", if_dout, 32'd0);
    push_word(32'h55);
    tick();
    check_eq("t6_post_dout", if_dout, 32'h55);
    check_eq("t6_post_nd", 32'(num_data_valid), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
